led_frame_sched: RTL

Frame scheduler that sequences the LED output path: it decides when the FIFO-fill FSM (`fifo_fsm`) starts a frame and snapshots the zone means it consumes. It waits for the serializer to finish and enforces the LED latch/reset gap. It re-sends the last frame periodically as a keep-alive. It sits between the colour-mean capture logic and `fifo_fsm`/serializer, replacing free-running start pulses.

---
 rtl/led_pkg.sv | 16 +
 rtl/led_cycle_timer.sv | 26 ++
 rtl/led_frame_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and sizes for the LED output path (frame scheduler and fifo_fsm).
package led_pkg;

    localparam int LED_ZONES = 8;
    localparam int MEAN_W    = 4;

    typedef logic [LED_ZONES-1:0][MEAN_W-1:0] mean_arr_t;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_FILL  = 2'd1,
        SCHED_SEND  = 2'd2,
        SCHED_LATCH = 2'd3
    } sched_state_t;

endpackage

// File: rtl/led_cycle_timer.sv
// Loadable down-counter that stops at zero; shared by the LATCH gap and the SEND watchdog.
module led_cycle_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/led_frame_sched.sv
// Frame scheduler for the LED path: starts fifo_fsm frames, snapshots zone means, enforces the latch gap and keep-alive.
// Define LED_SCHED_WDT_EN to enable the SEND watchdog and wdt_err; otherwise SEND waits for tx_done indefinitely.
module led_frame_sched
    import led_pkg::*;
#(
    parameter int LATCH_CYCLES   = 30000,
    parameter int REFRESH_CYCLES = 5000000,
    parameter int WDT_CYCLES     = 2000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sched_en,
    input  logic        frame_req,
    input  mean_arr_t   mean_r_i,
    input  mean_arr_t   mean_g_i,
    input  mean_arr_t   mean_b_i,
    input  logic        fill_done,
    input  logic        tx_done,
    output logic        fill_start,
    output mean_arr_t   mean_r_o,
    output mean_arr_t   mean_g_o,
    output mean_arr_t   mean_b_o,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [7:0]  drop_cnt,
    output logic        wdt_err
);

    localparam logic [1:0] ST_IDLE  = SCHED_IDLE;
    localparam logic [1:0] ST_FILL  = SCHED_FILL;
    localparam logic [1:0] ST_SEND  = SCHED_SEND;
    localparam logic [1:0] ST_LATCH = SCHED_LATCH;

    localparam logic [31:0] LATCH_LOAD  = 32'(LATCH_CYCLES - 1);
    localparam logic [31:0] WDT_LOAD    = 32'(WDT_CYCLES - 1);
    localparam logic [31:0] REFRESH_END = 32'(REFRESH_CYCLES - 1);
    // The hit is raised on the edge that brings the count to REFRESH_END, so the period is exact.
    localparam logic [31:0] REFRESH_PRE = 32'(REFRESH_CYCLES - 2);

    logic [1:0]  state, state_nxt;
    logic        pend, consume, refresh_hit, wdt_fire;
    logic [31:0] refresh_cnt;
    logic        tmr_load, tmr_zero;
    logic [31:0] tmr_value;
    mean_arr_t   stage_r, stage_g, stage_b;

    assign consume     = (state == ST_IDLE) && pend && sched_en;
    assign refresh_hit = (REFRESH_CYCLES != 0) && !consume && (refresh_cnt == REFRESH_PRE);

`ifdef LED_SCHED_WDT_EN
    assign wdt_fire = (state == ST_SEND) && tmr_zero && !tx_done;
`else
    assign wdt_fire = 1'b0;
`endif

    // The timer is always armed on SEND entry; it only matters when the watchdog is built in.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_value = LATCH_LOAD;
        case (state)
            ST_IDLE:  if (consume) state_nxt = ST_FILL;
            ST_FILL:  if (fill_done) begin
                          state_nxt = ST_SEND;
                          tmr_load  = 1'b1;
                          tmr_value = WDT_LOAD;
                      end
            ST_SEND:  if (tx_done || wdt_fire) begin
                          state_nxt = ST_LATCH;
                          tmr_load  = 1'b1;
                      end
            ST_LATCH: if (tmr_zero) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    led_cycle_timer #(.W(32)) u_timer (
        .clk   (clk),
        .rstn  (rstn),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            pend        <= 1'b0;
            fill_start  <= 1'b0;
            busy        <= 1'b0;
            stage_r     <= '0;
            stage_g     <= '0;
            stage_b     <= '0;
            mean_r_o    <= '0;
            mean_g_o    <= '0;
            mean_b_o    <= '0;
            frame_cnt   <= '0;
            drop_cnt    <= '0;
            wdt_err     <= 1'b0;
            refresh_cnt <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != ST_IDLE);
            fill_start <= consume;
            pend       <= (pend & ~consume) | frame_req | refresh_hit;
            if (frame_req) begin
                stage_r <= mean_r_i;
                stage_g <= mean_g_i;
                stage_b <= mean_b_i;
            end
            if (consume) begin
                mean_r_o  <= stage_r;
                mean_g_o  <= stage_g;
                mean_b_o  <= stage_b;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (frame_req && pend && !consume && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (wdt_fire) begin
                wdt_err <= 1'b1;
            end
            if (consume) begin
                refresh_cnt <= '0;
            end else if (refresh_cnt != REFRESH_END) begin
                refresh_cnt <= refresh_cnt + 32'd1;
            end
        end
    end

endmodule
